// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EMIT = 3'd1,
        ST_SUB  = 3'd2,
        ST_MIX  = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    localparam int          AES128_NUM_RK = 11;
    localparam logic [7:0]  RCON_INIT     = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_expand_ctrl_if.sv
// Round-key handshake towards the round datapath.
interface aes_key_expand_ctrl_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    modport master (output rk_valid, output rk_data, output rk_idx, input rk_ready);
    modport slave  (input rk_valid, input rk_data, input rk_idx, output rk_ready);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Pure lookup, no state.
    always_comb begin
        byte_o = sbox_byte(byte_i);
    end

endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel S-boxes, one per byte of a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (word_i[8*i +: 8]),
            .byte_o (word_o[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// Sequential AES-128 key expansion: emits round keys 0..10 over a valid/ready port.
module aes_key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int REG_SUBWORD = 0,
    parameter int NUM_RK      = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [127:0]                  key_in,
    aes_key_expand_ctrl_if.master         rk_if,
    output logic                          busy,
    output logic                          done
);

    if (NUM_RK != AES128_NUM_RK) begin : g_bad_num_rk
        $error("aes_key_expand_ctrl: NUM_RK must be 11 for AES-128");
    end

    state_e       state_q, state_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    word_t        sub_in_s;
    word_t        sub_out_s;
    word_t        sub_sel_s;
    word_t        t_s;
    word_t        w0n_s, w1n_s, w2n_s, w3n_s;
    logic         hs_s;
    logic         last_s;

    assign hs_s   = rk_valid_q && rk_if.rk_ready;
    assign last_s = (rk_idx_q == 4'(NUM_RK - 1));

    assign sub_in_s = rot_word(rk_data_q[31:0]);

    aes_subword u_subword (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    if (REG_SUBWORD != 0) begin : g_sub_reg
        word_t sub_q;

        // Pipeline stage for SubWord, loaded only in SUB.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sub_q <= 32'h0000_0000;
            end else if (state_q == ST_SUB) begin
                sub_q <= sub_out_s;
            end else begin
                sub_q <= sub_q;
            end
        end
        assign sub_sel_s = sub_q;
    end else begin : g_sub_comb
        assign sub_sel_s = sub_out_s;
    end

    assign t_s   = sub_sel_s ^ {rcon_q, 24'h00_0000};
    assign w0n_s = rk_data_q[127:96] ^ t_s;
    assign w1n_s = rk_data_q[95:64]  ^ w0n_s;
    assign w2n_s = rk_data_q[63:32]  ^ w1n_s;
    assign w3n_s = rk_data_q[31:0]   ^ w2n_s;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rk_data_q  <= 128'h0;
            rk_idx_q   <= 4'd0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_EMIT;
                else       state_d = ST_IDLE;
            end
            ST_EMIT: begin
                if (hs_s && last_s)         state_d = ST_FIN;
                else if (hs_s && (REG_SUBWORD != 0)) state_d = ST_SUB;
                else if (hs_s)              state_d = ST_MIX;
                else                        state_d = ST_EMIT;
            end
            ST_SUB:  state_d = ST_MIX;
            ST_MIX:  state_d = ST_EMIT;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Round-key datapath: key capture on start, schedule step in MIX.
    always_comb begin
        rk_data_d = rk_data_q;
        rk_idx_d  = rk_idx_q;
        rcon_d    = rcon_q;
        if ((state_q == ST_IDLE) && start) begin
            rk_data_d = key_in;
            rk_idx_d  = 4'd0;
            rcon_d    = RCON_INIT;
        end else if (state_q == ST_MIX) begin
            rk_data_d = {w0n_s, w1n_s, w2n_s, w3n_s};
            rk_idx_d  = rk_idx_q + 4'd1;
            rcon_d    = xtime(rcon_q);
        end else begin
            rk_data_d = rk_data_q;
            rk_idx_d  = rk_idx_q;
            rcon_d    = rcon_q;
        end
    end

    // Outputs decoded from the upcoming state so they register alongside it.
    always_comb begin
        rk_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            ST_IDLE: begin
                rk_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
            end
            ST_EMIT: begin
                rk_valid_d = 1'b1;
                busy_d     = 1'b1;
                done_d     = 1'b0;
            end
            ST_FIN: begin
                rk_valid_d = 1'b0;
                busy_d     = 1'b1;
                done_d     = 1'b1;
            end
            default: begin
                rk_valid_d = 1'b0;
                busy_d     = 1'b1;
                done_d     = 1'b0;
            end
        endcase
    end

    assign rk_if.rk_valid = rk_valid_q;
    assign rk_if.rk_data  = rk_data_q;
    assign rk_if.rk_idx   = rk_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Scoreboard bench: DUT0 (REG_SUBWORD=0) and DUT1 (REG_SUBWORD=1) against a FIPS-197 style model.
module tb_aes_key_expand_ctrl;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        int           idx;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   start = 2'b00;
    logic [1:0]   rdy = 2'b11;
    logic [1:0]   vld, busy, done_s;
    logic [127:0] key [2];
    logic [127:0] dat [2];
    logic [3:0]   idx [2];

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   start_cyc [2];
    exp_t exp_q [2][$];
    int   done_q [2][$];
    logic [127:0] ref_rk [11];

    aes_key_expand_ctrl_if rk_if [2] ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        ntests++;
        nfail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign rk_if[g].rk_ready = rdy[g];
        assign vld[g] = rk_if[g].rk_valid;
        assign dat[g] = rk_if[g].rk_data;
        assign idx[g] = rk_if[g].rk_idx;

        aes_key_expand_ctrl #(.REG_SUBWORD(g), .NUM_RK(11)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start[g]),
            .key_in (key[g]),
            .rk_if  (rk_if[g]),
            .busy   (busy[g]),
            .done   (done_s[g])
        );

        logic         prev_stall = 1'b0;
        logic [127:0] prev_dat;
        logic [3:0]   prev_idx;

        // Monitor: pops the scoreboard on every handshake and every done pulse.
        always @(negedge clk) begin : mon
            exp_t e;
            int   d;
            if (!rst_n) begin
                prev_stall <= 1'b0;
            end else begin
                if (vld[g] && prev_stall) begin
                    chk("stall_data", dat[g], prev_dat);
                    chk("stall_idx", 128'(idx[g]), 128'(prev_idx));
                end
                if (vld[g] && rdy[g]) begin
                    if (exp_q[g].size() == 0) begin
                        fail_now("unexpected_round_key");
                    end else begin
                        e = exp_q[g].pop_front();
                        chk("rk_idx", 128'(idx[g]), 128'(e.idx));
                        chk("rk_data", dat[g], e.data);
                        if (e.cyc >= 0) chk("rk_cycle", 128'(cyc - start_cyc[g] + 1), 128'(e.cyc));
                    end
                end
                if (done_s[g]) begin
                    if (done_q[g].size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        d = done_q[g].pop_front();
                        if (d >= 0) chk("done_cycle", 128'(cyc - start_cyc[g] + 1), 128'(d));
                    end
                end
                prev_stall <= vld[g] && !rdy[g];
                prev_dat   <= dat[g];
                prev_idx   <= idx[g];
            end
        end
    end

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Reference: textbook 44-word expansion.
    task automatic ref_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_w({t[23:0], t[31:24]}) ^ {RCON[i/4 - 1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_exp(input int g, input logic [127:0] k, input bit timed,
                             input int nkeys, input bit exp_done);
        ref_expand(k);
        for (int r = 0; r < nkeys; r++)
            exp_q[g].push_back('{r, ref_rk[r], timed ? 1 + r*(2+g) : -1});
        if (exp_done) done_q[g].push_back(timed ? 2 + 10*(2+g) : -1);
        key[g]   = k;
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        start_cyc[g] = cyc;
    endtask

    task automatic wait_done(input int g, input bit bp);
        int n = 0;
        int stall = 0;
        bit seen = 1'b0;
        while (!seen && n < 300) begin
            if (bp) begin
                if (stall > 0) begin
                    rdy[g] = 1'b0;
                    stall--;
                end else begin
                    rdy[g] = 1'b1;
                    stall = $urandom_range(0, 5);
                end
            end
            tick();
            n++;
            if (done_s[g]) seen = 1'b1;
        end
        rdy[g] = 1'b1;
        if (!seen) fail_now("done_timeout");
    endtask

    task automatic chk_reset_outputs(input int g);
        chk("rst_valid", 128'(vld[g]), 128'd0);
        chk("rst_data", dat[g], 128'd0);
        chk("rst_idx", 128'(idx[g]), 128'd0);
        chk("rst_busy", 128'(busy[g]), 128'd0);
        chk("rst_done", 128'(done_s[g]), 128'd0);
    endtask

    initial begin
        int  n;
        bit  hit;
        key[0] = 128'd0;
        key[1] = 128'd0;

        ref_expand(FIPS_KEY);
        chk("model_fips_rk1", ref_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_fips_rk10", ref_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        repeat (3) tick();
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst_n = 1'b1;
        tick();

        // FIPS key, ready tied high, exact timing; then restart right after FIN.
        start_exp(0, FIPS_KEY, 1'b1, 11, 1'b1);
        chk("first_valid", 128'(vld[0]), 128'd1);
        wait_done(0, 1'b0);
        tick();
        chk("idle_after_fin", 128'(busy[0]), 128'd0);
        start_exp(0, 128'd0, 1'b1, 11, 1'b1);
        chk("restart_valid", 128'(vld[0]), 128'd1);
        chk("zero_rk10_model", ref_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        wait_done(0, 1'b0);
        tick();

        // Random backpressure, fixed and random keys.
        start_exp(0, FIPS_KEY, 1'b0, 11, 1'b1);
        wait_done(0, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            start_exp(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 11, 1'b1);
            wait_done(0, 1'b1);
            tick();
        end

        // Registered SubWord variant with exact timing.
        start_exp(1, FIPS_KEY, 1'b1, 11, 1'b1);
        chk("reg_first_valid", 128'(vld[1]), 128'd1);
        wait_done(1, 1'b0);
        tick();

        // Ignored start at idx 4, then reset at idx 6.
        start_exp(0, FIPS_KEY, 1'b1, 6, 1'b0);
        n = 0;
        hit = 1'b0;
        while (!hit && n < 100) begin
            if (vld[0] && idx[0] == 4'd4 && !busy[1]) begin
                key[0] = {$urandom, $urandom, $urandom, $urandom};
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            if (vld[0] && idx[0] == 4'd6) begin
                hit = 1'b1;
                rst_n = 1'b0;
                #1;
                chk_reset_outputs(0);
            end else begin
                tick();
                n++;
            end
        end
        start[0] = 1'b0;
        if (!hit) fail_now("idx6_timeout");
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("abort_idle_valid", 128'(vld[0]), 128'd0);

        chk("sb0_drained", 128'(exp_q[0].size() + done_q[0].size()), 128'd0);
        chk("sb1_drained", 128'(exp_q[1].size() + done_q[1].size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
